// File: rtl/id_ex_pkg.sv
// Shared widths, occupancy states and payload layout for the ID/EX stage register.
package id_ex_pkg;

  localparam int DATA_W_D = 32;
  localparam int REG_W_D  = 5;
  localparam int WB_W_D   = 2;
  localparam int M_W_D    = 3;
  localparam int EX_W_D   = 4;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } occ_state_e;

  typedef struct packed {
    logic [WB_W_D-1:0] wb;
    logic [M_W_D-1:0]  m;
    logic [EX_W_D-1:0] ex;
  } ctrl_t;

  typedef struct packed {
    ctrl_t               ctrl;
    logic [DATA_W_D-1:0] data_a;
    logic [DATA_W_D-1:0] data_b;
    logic [DATA_W_D-1:0] imm;
    logic [REG_W_D-1:0]  rs;
    logic [REG_W_D-1:0]  rt;
    logic [REG_W_D-1:0]  rd;
  } payload_t;

  // Control groups sit in the MSBs of a packed payload so they can be cleared as one slice.
  function automatic int payload_width(input int data_w, input int reg_w,
                                       input int wb_w, input int m_w, input int ex_w);
    return wb_w + m_w + ex_w + 3 * data_w + 3 * reg_w;
  endfunction

endpackage

// File: rtl/id_ex_pipe_reg_entry.sv
// One stage entry: payload register plus valid bit. Clearing zeroes the control
// slice so an invalid entry always reads as a NOP; the data slice is retained.
module pipe_skid_entry #(
  parameter int W      = 8,
  parameter int CTRL_W = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         valid
);

  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clear) begin
      valid              <= 1'b0;
      q[W-1 -: CTRL_W]   <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with valid/ready handshake, two-entry skid buffer and flush.
//   state    | meaning
//   ST_EMPTY | no beat held, in_ready = 1
//   ST_ONE   | main holds a beat, skid empty, in_ready = 1
//   ST_TWO   | main and skid both hold beats, in_ready = 0
module id_ex_pipe_reg
  import id_ex_pkg::*;
#(
  parameter int DATA_W = DATA_W_D,
  parameter int REG_W  = REG_W_D,
  parameter int WB_W   = WB_W_D,
  parameter int M_W    = M_W_D,
  parameter int EX_W   = EX_W_D
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WB_W-1:0]   WB,
  input  logic [M_W-1:0]    M,
  input  logic [EX_W-1:0]   EX,
  input  logic [DATA_W-1:0] DataA,
  input  logic [DATA_W-1:0] DataB,
  input  logic [DATA_W-1:0] imm_value,
  input  logic [REG_W-1:0]  RegRs,
  input  logic [REG_W-1:0]  RegRt,
  input  logic [REG_W-1:0]  RegRd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WB_W-1:0]   WBreg,
  output logic [M_W-1:0]    Mreg,
  output logic [EX_W-1:0]   EXreg,
  output logic [DATA_W-1:0] DataAreg,
  output logic [DATA_W-1:0] DataBreg,
  output logic [DATA_W-1:0] imm_valuereg,
  output logic [REG_W-1:0]  RegRsreg,
  output logic [REG_W-1:0]  RegRtreg,
  output logic [REG_W-1:0]  RegRdreg
);

  localparam int CTRL_W = WB_W + M_W + EX_W;
  localparam int PW     = payload_width(DATA_W, REG_W, WB_W, M_W, EX_W);

  occ_state_e      state_q, state_d;
  logic            in_ready_q;
  logic            accept, consume;
  logic            main_valid, skid_valid;
  logic            main_load, main_clear, skid_load, skid_clear;
  logic [PW-1:0]   in_payload, main_d, main_q, skid_q;

  assign in_payload = {WB, M, EX, DataA, DataB, imm_value, RegRs, RegRt, RegRd};

  assign accept  = in_valid && in_ready_q && !flush;
  assign consume = main_valid && out_ready;

  // in_ready is registered from the next state so out_ready never reaches decode combinationally.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_TWO);
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: if (accept) state_d = ST_ONE;
        ST_ONE: begin
          if (accept && !consume)      state_d = ST_TWO;
          else if (!accept && consume) state_d = ST_EMPTY;
        end
        ST_TWO:   if (consume) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    main_load  = 1'b0;
    main_clear = flush;
    skid_load  = 1'b0;
    skid_clear = flush;
    main_d     = in_payload;
    if (!flush) begin
      unique case (state_q)
        ST_EMPTY: main_load = accept;
        ST_ONE: begin
          main_load  = accept && consume;
          main_clear = consume && !accept;
          skid_load  = accept && !consume;
        end
        ST_TWO: begin
          main_load  = consume;
          main_d     = skid_q;
          skid_clear = consume;
        end
        default: main_clear = 1'b1;
      endcase
    end
  end

  pipe_skid_entry #(.W(PW), .CTRL_W(CTRL_W)) u_main (
    .clock (clock),
    .reset (reset),
    .load  (main_load),
    .clear (main_clear),
    .d     (main_d),
    .q     (main_q),
    .valid (main_valid)
  );

  pipe_skid_entry #(.W(PW), .CTRL_W(CTRL_W)) u_skid (
    .clock (clock),
    .reset (reset),
    .load  (skid_load),
    .clear (skid_clear),
    .d     (in_payload),
    .q     (skid_q),
    .valid (skid_valid)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid;
  assign {WBreg, Mreg, EXreg, DataAreg, DataBreg, imm_valuereg,
          RegRsreg, RegRtreg, RegRdreg} = main_q;

  // Skid validity is implied by the occupancy state; kept visible for debug only.
  logic unused_skid_valid;
  assign unused_skid_valid = skid_valid;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: accepted beats are queued, a negedge monitor
// compares the DUT's head entry, occupancy and ready against the queue each cycle.
module tb_id_ex_pipe_reg;
  import id_ex_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic     reset = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  payload_t drv = '0;

  logic              in_ready, out_valid;
  logic [1:0]        WBreg;
  logic [2:0]        Mreg;
  logic [3:0]        EXreg;
  logic [31:0]       DataAreg, DataBreg, imm_valuereg;
  logic [4:0]        RegRsreg, RegRtreg, RegRdreg;
  payload_t          outp;

  id_ex_pipe_reg dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .WB(drv.ctrl.wb), .M(drv.ctrl.m), .EX(drv.ctrl.ex),
    .DataA(drv.data_a), .DataB(drv.data_b), .imm_value(drv.imm),
    .RegRs(drv.rs), .RegRt(drv.rt), .RegRd(drv.rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .WBreg(WBreg), .Mreg(Mreg), .EXreg(EXreg),
    .DataAreg(DataAreg), .DataBreg(DataBreg), .imm_valuereg(imm_valuereg),
    .RegRsreg(RegRsreg), .RegRtreg(RegRtreg), .RegRdreg(RegRdreg)
  );

  assign outp = {WBreg, Mreg, EXreg, DataAreg, DataBreg, imm_valuereg,
                 RegRsreg, RegRtreg, RegRdreg};

  int       n_checks = 0;
  int       n_pass   = 0;
  payload_t mq[$];
  int       dlog[$];
  bit       rflag    = 1'b1;
  bit       last_acc = 1'b0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  function automatic payload_t mk(input logic [31:0] a, input logic [1:0] wb,
                                  input logic [2:0] m, input logic [3:0] ex);
    payload_t p;
    p.ctrl.wb = wb;
    p.ctrl.m  = m;
    p.ctrl.ex = ex;
    p.data_a  = a;
    p.data_b  = a ^ 32'hA5A5_0000;
    p.imm     = a + 32'd100;
    p.rs      = a[4:0];
    p.rt      = ~a[4:0];
    p.rd      = a[4:0] + 5'd1;
    return p;
  endfunction

  // Reference queue: consume pops the head, flush empties, accept appends.
  always @(posedge clock) begin
    bit acc, cons;
    if (out_valid === 1'b1 && out_ready) dlog.push_back(int'(DataAreg));
    if (reset) begin
      mq.delete();
      rflag    = 1'b1;
      last_acc = 1'b0;
    end else begin
      acc  = in_valid && !rflag && (mq.size() < 2) && !flush;
      cons = (mq.size() > 0) && out_ready;
      if (cons) void'(mq.pop_front());
      if (flush) mq.delete();
      else if (acc) mq.push_back(drv);
      last_acc = acc;
      rflag    = 1'b0;
    end
  end

  always @(negedge clock) begin
    check("out_valid", 128'(out_valid), 128'(mq.size() > 0));
    check("in_ready", 128'(in_ready), 128'(!rflag && (mq.size() < 2)));
    if (mq.size() > 0) check("payload", 128'(outp), 128'(mq[0]));
    else check("bubble_ctrl", 128'({WBreg, Mreg, EXreg}), 128'(0));
  end

  task automatic send(input payload_t p);
    drv      = p;
    in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (last_acc) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    n_checks++;
    $display("FAIL send_timeout: beat %h not accepted within 40 cycles", p.data_a);
  endtask

  initial begin
    logic [127:0] r;
    // Reset held two cycles with a live input beat.
    drv = mk(32'h7, 2'b11, 3'b111, 4'hF);
    in_valid = 1'b1;
    repeat (2) begin
      @(negedge clock);
      check("reset_out_valid", 128'(out_valid), 128'(0));
      check("reset_in_ready", 128'(in_ready), 128'(0));
      check("reset_wbreg", 128'(WBreg), 128'(0));
      check("reset_dataa", 128'(DataAreg), 128'(0));
    end
    reset = 1'b0;
    in_valid = 1'b0;
    @(negedge clock);
    check("ready_after_reset", 128'(in_ready), 128'(1));

    // Streaming at full rate.
    out_ready = 1'b1;
    dlog.delete();
    for (int i = 1; i <= 8; i++) send(mk(32'(i), 2'd1, 3'd2, 4'd3));
    repeat (3) @(negedge clock);
    check("stream_count", 128'(dlog.size()), 128'(8));
    for (int i = 0; i < 8; i++)
      check("stream_order", 128'(i < dlog.size() ? dlog[i] : -1), 128'(i + 1));

    // Downstream stall fills the skid, then drains in order.
    out_ready = 1'b0;
    dlog.delete();
    send(mk(32'h10, 2'd1, 3'd1, 4'd1));
    send(mk(32'h11, 2'd1, 3'd1, 4'd1));
    check("stall_in_ready", 128'(in_ready), 128'(0));
    drv = mk(32'h12, 2'd1, 3'd1, 4'd1);
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("stall_hold", 128'(in_ready), 128'(0));
    end
    out_ready = 1'b1;
    send(mk(32'h12, 2'd1, 3'd1, 4'd1));
    repeat (4) @(negedge clock);
    check("stall_count", 128'(dlog.size()), 128'(3));
    for (int i = 0; i < 3; i++)
      check("stall_order", 128'(i < dlog.size() ? dlog[i] : -1), 128'(32'h10 + i));

    // Flush with both entries full and a beat on the input.
    out_ready = 1'b0;
    dlog.delete();
    send(mk(32'h20, 2'd0, 3'b101, 4'd0));
    send(mk(32'h21, 2'd0, 3'b101, 4'd0));
    drv = mk(32'h22, 2'd0, 3'b101, 4'd0);
    in_valid = 1'b1;
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", 128'(out_valid), 128'(0));
    check("flush_mreg", 128'(Mreg), 128'(0));
    check("flush_in_ready", 128'(in_ready), 128'(1));
    out_ready = 1'b1;
    repeat (3) @(negedge clock);
    check("flush_no_output", 128'(dlog.size()), 128'(0));

    // Consumed beat with nothing behind it leaves a bubble.
    out_ready = 1'b0;
    dlog.delete();
    send(mk(32'h55, 2'd2, 3'd1, 4'hF));
    out_ready = 1'b1;
    @(negedge clock);
    check("bubble_exreg", 128'(EXreg), 128'(0));
    check("bubble_wbreg", 128'(WBreg), 128'(0));
    check("bubble_dataa", 128'(DataAreg), 128'(32'h55));
    check("bubble_out_valid", 128'(out_valid), 128'(0));
    check("bubble_delivered", 128'(dlog.size() > 0 ? dlog[0] : -1), 128'(32'h55));

    // Flush in the same cycle as consume still delivers that beat.
    out_ready = 1'b0;
    dlog.delete();
    send(mk(32'h66, 2'd3, 3'd3, 4'd3));
    out_ready = 1'b1;
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    check("flushcons_count", 128'(dlog.size()), 128'(1));
    check("flushcons_beat", 128'(dlog.size() > 0 ? dlog[0] : -1), 128'(32'h66));
    check("flushcons_out_valid", 128'(out_valid), 128'(0));

    // Random traffic against the reference queue.
    for (int c = 0; c < 10000; c++) begin
      @(negedge clock);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 99) < 3);
      r = {$urandom(), $urandom(), $urandom(), $urandom()};
      drv = r[119:0];
    end
    @(negedge clock);
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe_reg.md
# id_ex_pipe_reg

Parametrised ID/EX pipeline register and the successor to the plain always-latching stage register. It sits between decode and execute and carries the WB, M and EX control groups, operands A and B, the immediate, and the Rs/Rt/Rd register numbers. It adds a valid/ready handshake with a two-entry skid buffer, so a downstream stall does not combinationally reach decode. It also adds a synchronous flush that turns in-flight entries into bubbles, for branch and hazard squash.

## Interface
- DATA_W, 32, width of DataA, DataB and imm_value
- REG_W, 5, width of the RegRs, RegRt and RegRd register numbers
- WB_W, 2, width of the WB control group
- M_W, 3, width of the M control group
- EX_W, 4, width of the EX control group
- clock  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high; clears all state
- flush  in  1  synchronous squash of both entries; the input beat in the same cycle is dropped
- in_valid  in  1  decode presents a beat
- in_ready  out  1  stage can accept; equals "skid empty", driven from a register
- WB, M, EX  in  WB_W/M_W/EX_W  control groups
- DataA, DataB, imm_value  in  DATA_W each  operands
- RegRs, RegRt, RegRd  in  REG_W each  register numbers
- out_valid  out  1  main entry holds a beat
- out_ready  in  1  execute consumes the beat this cycle
- WBreg, Mreg, EXreg, DataAreg, DataBreg, imm_valuereg, RegRsreg, RegRtreg, RegRdreg  out  as inputs  fields of the main entry

## Operation
- Storage: a main entry (drives the outputs) and a skid entry. Each entry holds all nine fields plus a valid bit.
- Handshakes:
  - accept = in_valid && in_ready && !flush
  - consume = out_valid && out_ready
- States follow from {main valid, skid valid}: EMPTY, ONE, TWO.
- EMPTY:
  - accept → ONE, with main loaded from the inputs.
- ONE:
  - accept && consume → ONE, main reloaded from the inputs
  - accept only → TWO, skid loaded from the inputs
  - consume only → EMPTY
  - neither → hold
- TWO (in_ready = 0):
  - consume → ONE, main loaded from skid and skid cleared
  - otherwise → hold
- Bubble rule: whenever main becomes invalid, WBreg, Mreg and EXreg are cleared to 0. Execute therefore sees a NOP even if it ignores out_valid. Data and register fields keep their last value when main is not valid.
- flush: both valid bits go to 0 and all control fields of both entries go to 0 at the next edge, from any state.
- Priority: reset > flush > handshake.
- A beat presented with in_valid while in_ready = 0 is not captured. Decode must hold it.
- Ordering is strict FIFO; no beat is duplicated or lost except by flush.

## Timing
- Reset value of every output is 0, including in_ready. The cycle after reset deasserts, in_ready = 1.
- Latency: a beat accepted at edge N appears on the outputs with out_valid = 1 after edge N.
- Throughput: one beat per cycle while out_ready stays high.
- Outputs and in_ready are register outputs with no combinational path from out_ready.
- Stall boundary: a downstream stall is seen at in_ready after one edge. The skid entry absorbs the single beat already in flight.
- Reset or flush asserted mid-transfer: the state after the edge is EMPTY regardless of in_valid and out_ready.
- Flush together with consume: the consumed beat counts as delivered in that cycle. The next state is EMPTY.

## Structure
- Package id_ex_pkg holds:
  - default width constants
  - a packed struct typedef for the control groups (WB, M, EX)
  - a packed struct for the payload
- Natural sub-module: pipe_skid_entry, one payload register plus valid bit with load and clear inputs. It is instantiated twice (main and skid).
- The top-level module holds the three-state next-state logic and field unpacking.

## Test plan
- Reset: hold reset 2 cycles with in_valid = 1 and WB = 2'b11 → all outputs 0, out_valid = 0, in_ready = 0 during reset and 1 one cycle after.
- Streaming: 8 beats with DataA = 1..8 and out_ready held at 1 → DataAreg shows 1..8 on consecutive cycles one cycle after each input, no gaps.
- Stall: send beats A = 0x10, 0x11, 0x12 and drop out_ready after the first is accepted → in_ready falls after 0x11 is stored in skid. Raise out_ready → 0x10, 0x11, 0x12 delivered in order; no loss or duplicate.
- Flush in TWO: hold beats with M = 3'b101 in both entries, pulse flush with in_valid = 1 → next cycle out_valid = 0, Mreg = 0, in_ready = 1, and the flush-cycle input is never output.
- Bubble: one beat with EX = 4'hF is consumed with no new input → next cycle EXreg = 0, WBreg = 0 and DataAreg retains its value.
- Random: random in_valid, out_ready and flush over 10k cycles → scoreboard order matches, and every output beat was accepted and not flushed.
